// File: rtl/alu_pkg.sv
// Shared operand/opcode types and the ADD/SUB datapath helpers.
// Used by alu_responder; ALU_RSP_ERR_EN enables the optional error bit there.
package alu_pkg;

  localparam int ALU_RES_W = 32;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
  } op_t;

  typedef enum logic [31:0] {
    ADD = 32'd0,
    SUB = 32'd1
  } opcode_t;

  // Anything outside ADD/SUB produces a zero result.
  function automatic logic [ALU_RES_W-1:0] alu_result(input op_t ops, input logic [31:0] opc);
    logic [ALU_RES_W-1:0] res;
    case (opc)
      ADD:     res = ops.op1 + ops.op2;
      SUB:     res = ops.op1 - ops.op2;
      default: res = {ALU_RES_W{1'b0}};
    endcase
    return res;
  endfunction

  function automatic logic alu_legal(input logic [31:0] opc);
    logic ok;
    case (opc)
      ADD:     ok = 1'b1;
      SUB:     ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous power-of-two FIFO with registered storage and no read bypass.
// The head word is always the storage entry at the read pointer.
module resp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              push_s;
  logic              pop_s;

  // Overflowing pushes and underflowing pops are dropped here as well as upstream.
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign full   = (count_r == CNT_FULL);
  assign empty  = (count_r == {(PTR_W+1){1'b0}});
  assign rdata  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_responder.sv
// Flow-controlled ADD/SUB responder: results queue in resp_fifo and drain on rsp_*.
// Define ALU_RSP_ERR_EN to carry an illegal-opcode flag per entry on rsp_err.
module alu_responder
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_operands,
  input  logic [31:0]      req_opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_res,
`ifdef ALU_RSP_ERR_EN
  output logic             rsp_err,
`endif
  output logic [CNT_W-1:0] done_cnt
);

`ifdef ALU_RSP_ERR_EN
  localparam int ENT_W = ALU_RES_W + 1;
`else
  localparam int ENT_W = ALU_RES_W;
`endif
  localparam logic [CNT_W-1:0] DONE_ONE = CNT_W'(1);

  op_t                  ops_s;
  logic [ALU_RES_W-1:0] res_s;
  logic [ENT_W-1:0]     wdata_s;
  logic [ENT_W-1:0]     head_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic [CNT_W-1:0]     done_cnt_r;

  assign ops_s = req_operands;

  // Opcode decode and result mux for the request currently offered.
  always_comb begin
    res_s = alu_result(ops_s, req_opcode);
`ifdef ALU_RSP_ERR_EN
    wdata_s = {~alu_legal(req_opcode), res_s};
`else
    wdata_s = res_s;
`endif
  end

  // Ready depends only on registered occupancy, never on rsp_ready.
  assign req_ready = ~full_s;
  assign rsp_valid = ~empty_s;
  assign push_s    = req_valid & ~full_s;
  assign pop_s     = rsp_ready & ~empty_s;
  assign rsp_res   = head_s[ALU_RES_W-1:0];
`ifdef ALU_RSP_ERR_EN
  assign rsp_err   = head_s[ALU_RES_W];
`endif
  assign done_cnt  = done_cnt_r;

  resp_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .full  (full_s),
    .empty (empty_s),
    .rdata (head_s)
  );

  // Completed-response counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      done_cnt_r <= done_cnt_r + DONE_ONE;
    end else begin
      done_cnt_r <= done_cnt_r;
    end
  end

endmodule
